sha3_block_padder: RTL and testbench

- Sequential front-end of the SHA3-256 core.
- Accepts the message as a stream of 64-bit words and packs them into one 1088-bit rate block (17 words).
- Applies SHA3 padding after the final message word: domain byte 0x06, then zero fill, then 0x80 in the last byte of the block.
- Presents each full block to the downstream permutation stage and holds it until that stage acknowledges.

---
 rtl/sha3_block_padder.sv | 155 +++++++++++++++
 tb/tb_sha3_block_padder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_block_padder.sv
// SHA3-256 front-end: packs 64-bit message words into 1088-bit rate
// blocks, appends 0x06..0x80 padding and holds each block until acked.
module sha3_block_padder #(
  parameter int RATE_WORDS = 17
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [63:0]              in,
  input  logic                     in_ready,
  input  logic                     is_last,
  input  logic [3:0]               byte_num,
  output logic                     buffer_full,
  output logic [RATE_WORDS*64-1:0] out,
  output logic                     out_ready,
  input  logic                     f_ack,
  output logic                     done
);

  localparam int CW = $clog2(RATE_WORDS);
  localparam logic [CW-1:0] LAST = CW'(RATE_WORDS - 1);
  localparam logic [63:0] PAD06 = 64'h0600000000000000;

  localparam logic [1:0] S_ACCEPT = 2'd0;
  localparam logic [1:0] S_PAD    = 2'd1;
  localparam logic [1:0] S_FULL   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic          pad_pending;
  logic          is_final;

  logic          wr;
  logic [63:0]   wdata;
  logic          fin;
  logic          fin_w;
  logic          pend_set;
  logic          pend_clr;
  logic          last_slot;
  logic [1:0]    wr_next;

  function automatic logic [63:0] pad_last(
    input logic [63:0] w,
    input logic [3:0]  k
  );
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(k))
        r[63-8*i -: 8] = w[63-8*i -: 8];
      else if (i == int'(k))
        r[63-8*i -: 8] = 8'h06;
    end
    return r;
  endfunction

  assign out_ready = buffer_full;
  assign last_slot = (count == LAST);
  assign fin_w     = fin && last_slot;

  always_comb begin
    wr       = 1'b0;
    wdata    = '0;
    fin      = 1'b0;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    wr_next  = state;
    unique case (state)
      S_ACCEPT: begin
        if (in_ready && !buffer_full) begin
          wr = 1'b1;
          if (is_last) begin
            wr_next = S_PAD;
            if (byte_num >= 4'd8) begin
              wdata    = in;
              pend_set = 1'b1;
            end else begin
              wdata = pad_last(in, byte_num);
              fin   = 1'b1;
            end
          end else begin
            wdata = in;
          end
        end
      end
      S_PAD: begin
        wr       = 1'b1;
        wdata    = pad_pending ? PAD06 : 64'h0;
        pend_clr = pad_pending;
        fin      = 1'b1;
      end
      S_FULL: begin
        wr = 1'b0;
      end
      S_DONE: begin
        wr = 1'b0;
      end
    endcase
    // Closing byte of the whole padded message
    if (fin_w)
      wdata[7:0] = wdata[7:0] | 8'h80;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_ACCEPT;
      count       <= '0;
      pad_pending <= 1'b0;
      is_final    <= 1'b0;
      buffer_full <= 1'b0;
      done        <= 1'b0;
      out         <= '0;
    end else begin
      unique case (state)
        S_ACCEPT, S_PAD: begin
          if (wr) begin
            for (int i = 0; i < RATE_WORDS; i++)
              if (count == CW'(i))
                out[(RATE_WORDS-1-i)*64 +: 64] <= wdata;
            if (pend_set)
              pad_pending <= 1'b1;
            else if (pend_clr)
              pad_pending <= 1'b0;
            if (last_slot) begin
              buffer_full <= 1'b1;
              is_final    <= fin;
              state       <= S_FULL;
            end else begin
              count <= count + CW'(1);
              state <= wr_next;
            end
          end
        end
        S_FULL: begin
          if (f_ack) begin
            buffer_full <= 1'b0;
            count       <= '0;
            out         <= '0;
            done        <= is_final;
            if (is_final)
              state <= S_DONE;
            else if (pad_pending)
              state <= S_PAD;
            else
              state <= S_ACCEPT;
          end
        end
        S_DONE: begin
          done <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_block_padder.sv
// Randomized bench for sha3_block_padder against a byte-level
// SHA3 padding model (message bytes, 0x06, zero fill, 0x80).
module tb_sha3_block_padder;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [63:0]   in_w = '0;
  logic          in_ready = 1'b0;
  logic          is_last = 1'b0;
  logic [3:0]    byte_num = '0;
  logic          buffer_full;
  logic [1087:0] out_blk;
  logic          out_ready;
  logic          f_ack = 1'b0;
  logic          done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit hold = 1'b0;

  logic [63:0] msg_w[$];
  logic [63:0] exp_w[$];

  sha3_block_padder #(.RATE_WORDS(17)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in(in_w),
    .in_ready(in_ready),
    .is_last(is_last),
    .byte_num(byte_num),
    .buffer_full(buffer_full),
    .out(out_blk),
    .out_ready(out_ready),
    .f_ack(f_ack),
    .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] oword(input int w);
    return out_blk[1087-64*w -: 64];
  endfunction

  // Byte-level padding model
  task automatic build(input int k);
    logic [7:0]  q[$];
    logic [63:0] w;
    int n;
    int nb;
    n = msg_w.size();
    for (int i = 0; i < n; i++) begin
      w = msg_w[i];
      nb = (i == n - 1) ? k : 8;
      for (int b = 0; b < nb; b++) q.push_back(w[63-8*b -: 8]);
    end
    q.push_back(8'h06);
    while (q.size() % 136 != 0) q.push_back(8'h00);
    q[q.size()-1] = q[q.size()-1] | 8'h80;
    exp_w.delete();
    for (int i = 0; i < q.size() / 8; i++) begin
      w = '0;
      for (int b = 0; b < 8; b++) w = {w[55:0], q[8*i+b]};
      exp_w.push_back(w);
    end
  endtask

  task automatic drive(input int i, input int k);
    in_w     = msg_w[i];
    in_ready = 1'b1;
    is_last  = (i == msg_w.size() - 1);
    byte_num = is_last ? 4'(k) : 4'($urandom_range(0, 8));
  endtask

  task automatic junk();
    in_ready = 1'($urandom_range(0, 1));
    in_w     = {$urandom, $urandom};
    is_last  = 1'($urandom_range(0, 1));
    byte_num = 4'($urandom_range(0, 8));
  endtask

  task automatic do_reset();
    in_ready = 1'b0;
    f_ack    = 1'b0;
    is_last  = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_full", {63'b0, buffer_full}, 64'd0);
    check("rst_oready", {63'b0, out_ready}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_out", {63'b0, |out_blk}, 64'd0);
    reset_n = 1'b1;
  endtask

  task automatic fill(input int n);
    msg_w.delete();
    repeat (n) msg_w.push_back({$urandom, $urandom});
  endtask

  task automatic run_msg(input int k);
    int n;
    int nblk;
    int bi;
    int wi;
    int lb;
    int s;
    int acc_cyc;
    int pidx;
    int t0;
    bit pend;
    build(k);
    n = msg_w.size();
    nblk = exp_w.size() / 17;
    lb = (n - 1) / 17;
    s = (n - 1) % 17;
    bi = 0;
    wi = 0;
    pend = 1'b0;
    acc_cyc = 0;
    pidx = 0;
    t0 = cyc;
    @(negedge clk);
    while (bi < nblk && cyc - t0 < 3000) begin
      if (pend) begin
        check("slot", oword(pidx % 17), exp_w[pidx]);
        pend = 1'b0;
      end
      if (buffer_full) begin
        f_ack = 1'b0;
        if (bi == lb)
          check("latency", 64'(cyc - acc_cyc),
                64'((s == 16) ? 0 : 16 - s));
        check("out_ready", {63'b0, out_ready}, 64'd1);
        for (int w = 0; w < 17; w++)
          check("block", oword(w), exp_w[17*bi+w]);
        if (wi < n) drive(wi, k);
        else junk();
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          check("frozen0", oword(0), exp_w[17*bi]);
          check("frozen16", oword(16), exp_w[17*bi+16]);
          check("hold_full", {63'b0, buffer_full}, 64'd1);
        end
        f_ack = 1'b1;
        @(negedge clk);
        f_ack = 1'b0;
        check("ack_clear", {63'b0, buffer_full}, 64'd0);
        check("ack_out", {63'b0, |out_blk}, 64'd0);
        check("done", {63'b0, done}, (bi == nblk - 1) ? 64'd1 : 64'd0);
        bi++;
        continue;
      end
      f_ack = ($urandom_range(0, 7) == 0);
      if (wi < n && (hold || $urandom_range(0, 3) != 0)) begin
        drive(wi, k);
        pend = 1'b1;
        pidx = wi;
        if (wi == n - 1) acc_cyc = cyc + 1;
        wi++;
      end else if (wi < n) begin
        in_ready = 1'b0;
        in_w = {$urandom, $urandom};
      end else begin
        junk();
      end
      @(negedge clk);
    end
    f_ack = 1'b0;
    in_ready = 1'b0;
    check("blocks_seen", 64'(bi), 64'(nblk));
    repeat (3) @(negedge clk);
    check("done_hold", {63'b0, done}, 64'd1);
    check("idle_full", {63'b0, buffer_full}, 64'd0);
  endtask

  initial begin
    do_reset();
    msg_w = {64'h1234567890ABCDEF};
    run_msg(3);

    do_reset();
    fill(1);
    run_msg(0);

    do_reset();
    fill(17);
    msg_w[16] = 64'h1234567890ABCDEF;
    run_msg(7);

    do_reset();
    fill(17);
    run_msg(8);

    do_reset();
    hold = 1'b1;
    fill(20);
    run_msg($urandom_range(0, 8));
    hold = 1'b0;

    do_reset();
    fill(1);
    build(5);
    @(negedge clk);
    drive(0, 5);
    @(negedge clk);
    in_ready = 1'b0;
    check("pre_rst", oword(0), exp_w[0]);
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_full", {63'b0, buffer_full}, 64'd0);
    check("async_oready", {63'b0, out_ready}, 64'd0);
    check("async_done", {63'b0, done}, 64'd0);
    check("async_out", {63'b0, |out_blk}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    fill(1);
    run_msg($urandom_range(0, 8));

    repeat (20) begin
      do_reset();
      fill($urandom_range(1, 40));
      run_msg($urandom_range(0, 8));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
